// File: rtl/dma_write_splitter_if.sv
// Handshake bundles shared by the DMA write splitter and its neighbours:
// a memory command channel and a 512-bit AXI-stream data channel.
interface axis_mem_cmd #(
    parameter int ADDR_W = 64,
    parameter int LEN_W  = 32
);
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] address;
    logic [LEN_W-1:0]  length;

    modport master (output valid, output address, output length, input ready);
    modport slave  (input valid, input address, input length, output ready);
endinterface

interface axi_stream #(
    parameter int DATA_W = 512
);
    logic                valid;
    logic                ready;
    logic [DATA_W-1:0]   data;
    logic [DATA_W/8-1:0] keep;
    logic                last;

    modport master (output valid, output data, output keep, output last, input ready);
    modport slave  (input valid, input data, input keep, input last, output ready);
endinterface

// File: rtl/dma_write_splitter.sv
// Splits DMA write commands into chunks that never cross a MAX_CHUNK-aligned
// boundary and regenerates the data-stream last flag at every chunk end.
module dma_write_splitter #(
    parameter int MAX_CHUNK  = 4096,
    parameter int BEAT_BYTES = 64
) (
    input  logic        clk,
    input  logic        rstn,
    axis_mem_cmd.slave  s_cmd,
    axi_stream.slave    s_data,
    axis_mem_cmd.master m_cmd,
    axi_stream.master   m_data,
    output logic [31:0] chunk_count,
    output logic [31:0] zero_len_count,
    output logic [31:0] last_mismatch_count
);
    localparam logic [31:0] CHUNK_W    = 32'(MAX_CHUNK);
    localparam logic [31:0] CHUNK_MASK = CHUNK_W - 32'd1;
    localparam int          BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam logic [63:0] ADDR_LOW   = 64'(BEAT_BYTES - 1);
    localparam logic [31:0] LEN_LOW    = 32'(BEAT_BYTES - 1);

    typedef enum logic [1:0] {IDLE, CALC, ISSUE, DATA} state_t;

    state_t      state_q;
    logic [63:0] cur_addr_q;
    logic [31:0] remain_q;
    logic [63:0] cmd_addr_q;
    logic [31:0] cmd_len_q;
    logic [31:0] beats_q;
    logic [31:0] beat_cnt_q;
    logic        cmd_valid_q;
    logic        cmd_ready_q;
    logic [31:0] chunk_count_q;
    logic [31:0] zero_len_count_q;
    logic [31:0] mismatch_count_q;

    logic [31:0] room;
    logic [31:0] chunk;
    logic [63:0] in_addr;
    logic [31:0] in_len;
    logic        in_data;
    logic        final_beat;
    logic        cmd_fire;
    logic        data_fire;
    logic        expect_up_last;

    assign in_addr        = s_cmd.address & ~ADDR_LOW;
    assign in_len         = s_cmd.length & ~LEN_LOW;
    assign room           = CHUNK_W - (cur_addr_q[31:0] & CHUNK_MASK);
    assign chunk          = (remain_q < room) ? remain_q : room;
    assign in_data        = (state_q == DATA);
    assign final_beat     = (beat_cnt_q == beats_q - 32'd1);
    assign cmd_fire       = s_cmd.valid && cmd_ready_q;
    assign data_fire      = in_data && s_data.valid && m_data.ready;
    // remain_q is already reduced by the current chunk once DATA is entered.
    assign expect_up_last = final_beat && (remain_q == 32'd0);

    assign s_cmd.ready    = cmd_ready_q;
    assign m_cmd.valid    = cmd_valid_q;
    assign m_cmd.address  = cmd_addr_q;
    assign m_cmd.length   = cmd_len_q;

    assign m_data.valid   = in_data && s_data.valid;
    assign s_data.ready   = in_data && m_data.ready;
    assign m_data.data    = s_data.data;
    assign m_data.keep    = s_data.keep;
    assign m_data.last    = in_data && final_beat;

    assign chunk_count         = chunk_count_q;
    assign zero_len_count      = zero_len_count_q;
    assign last_mismatch_count = mismatch_count_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q          <= IDLE;
            cur_addr_q       <= '0;
            remain_q         <= '0;
            cmd_addr_q       <= '0;
            cmd_len_q        <= '0;
            beats_q          <= '0;
            beat_cnt_q       <= '0;
            cmd_valid_q      <= 1'b0;
            cmd_ready_q      <= 1'b0;
            chunk_count_q    <= '0;
            zero_len_count_q <= '0;
            mismatch_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_fire) begin
                        cur_addr_q <= in_addr;
                        remain_q   <= in_len;
                        if (in_len == 32'd0) begin
                            zero_len_count_q <= zero_len_count_q + 32'd1;
                        end else begin
                            cmd_ready_q <= 1'b0;
                            state_q     <= CALC;
                        end
                    end
                end
                CALC: begin
                    cmd_addr_q  <= cur_addr_q;
                    cmd_len_q   <= chunk;
                    beats_q     <= chunk >> BEAT_SHIFT;
                    cmd_valid_q <= 1'b1;
                    state_q     <= ISSUE;
                end
                ISSUE: begin
                    if (m_cmd.ready) begin
                        cmd_valid_q   <= 1'b0;
                        chunk_count_q <= chunk_count_q + 32'd1;
                        cur_addr_q    <= cur_addr_q + {32'd0, cmd_len_q};
                        remain_q      <= remain_q - cmd_len_q;
                        beat_cnt_q    <= '0;
                        state_q       <= DATA;
                    end
                end
                DATA: begin
                    if (data_fire) begin
                        if (s_data.last != expect_up_last) begin
                            mismatch_count_q <= mismatch_count_q + 32'd1;
                        end
                        if (final_beat) begin
                            if (remain_q != 32'd0) begin
                                state_q <= CALC;
                            end else begin
                                state_q     <= IDLE;
                                cmd_ready_q <= 1'b1;
                            end
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 32'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_write_splitter.sv
// Scoreboard bench for dma_write_splitter: directed commands push expected
// chunks and beats; a negedge monitor pops and compares every output handshake.
module tb_dma_write_splitter;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    axis_mem_cmd s_cmd_if ();
    axi_stream   s_data_if ();
    axis_mem_cmd m_cmd_if ();
    axi_stream   m_data_if ();

    logic [31:0] chunk_count;
    logic [31:0] zero_len_count;
    logic [31:0] last_mismatch_count;

    dma_write_splitter #(.MAX_CHUNK(4096), .BEAT_BYTES(64)) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .s_cmd               (s_cmd_if),
        .s_data              (s_data_if),
        .m_cmd               (m_cmd_if),
        .m_data              (m_data_if),
        .chunk_count         (chunk_count),
        .zero_len_count      (zero_len_count),
        .last_mismatch_count (last_mismatch_count)
    );

    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] len;
    } cmd_t;

    typedef struct packed {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         last;
    } beat_t;

    cmd_t  exp_cmd_q[$];
    beat_t exp_beat_q[$];

    int          checks   = 0;
    int          failures = 0;
    int unsigned exp_seq  = 0;
    int unsigned drv_seq  = 0;
    logic        data_done;

    function automatic logic [511:0] word_of(int unsigned s);
        logic [31:0] v;
        v = s;
        return {8{v, ~v ^ 32'h5A5A_0000}};
    endfunction

    function automatic logic [63:0] keep_of(int unsigned s);
        logic [31:0] v;
        v = s;
        return {~v, v ^ 32'h0F0F_F0F0};
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_chunk(input logic [63:0] addr, input logic [31:0] len, input bit final_cmd);
        cmd_t  c;
        beat_t b;
        int    nb;
        c.addr = addr;
        c.len  = len;
        exp_cmd_q.push_back(c);
        nb = int'(len / 64);
        for (int i = 0; i < nb; i++) begin
            b.data = word_of(exp_seq);
            b.keep = keep_of(exp_seq);
            b.last = (i == nb - 1);
            exp_beat_q.push_back(b);
            exp_seq++;
        end
        if (final_cmd) begin
            // nothing extra: upstream last is not forwarded
        end
    endtask

    // Monitor: every downstream handshake is compared against the scoreboard.
    always @(negedge clk) begin
        cmd_t  c;
        beat_t b;
        if (rstn && m_cmd_if.valid && m_cmd_if.ready) begin
            if (exp_cmd_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_m_cmd actual=%0h/%0h required=none",
                         m_cmd_if.address, m_cmd_if.length);
            end else begin
                c = exp_cmd_q.pop_front();
                chk("m_cmd.address", 512'(m_cmd_if.address), 512'(c.addr));
                chk("m_cmd.length",  512'(m_cmd_if.length),  512'(c.len));
            end
        end
        if (rstn && m_data_if.valid && m_data_if.ready) begin
            if (exp_beat_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual=%0h required=none", m_data_if.keep);
            end else begin
                b = exp_beat_q.pop_front();
                chk("m_data.data", m_data_if.data, b.data);
                chk("m_data.keep", 512'(m_data_if.keep), 512'(b.keep));
                chk("m_data.last", 512'(m_data_if.last), 512'(b.last));
            end
        end
    end

    task automatic send_cmd(input logic [63:0] addr, input logic [31:0] len);
        int n;
        @(posedge clk);
        #1;
        s_cmd_if.valid   = 1'b1;
        s_cmd_if.address = addr;
        s_cmd_if.length  = len;
        n = 0;
        @(negedge clk);
        while (!s_cmd_if.ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            failures++;
            $display("FAIL s_cmd_timeout actual=ready0 required=ready1");
        end
        @(posedge clk);
        #1;
        s_cmd_if.valid = 1'b0;
    endtask

    // Sends n beats; upstream last is raised on 1-based beat last_idx (0 = never).
    task automatic send_data(input int n, input int last_idx);
        int w;
        for (int i = 0; i < n; i++) begin
            s_data_if.valid = 1'b1;
            s_data_if.data  = word_of(drv_seq);
            s_data_if.keep  = keep_of(drv_seq);
            s_data_if.last  = (i + 1 == last_idx);
            w = 0;
            @(negedge clk);
            while (!s_data_if.ready && w < 2000) begin
                @(negedge clk);
                w++;
            end
            if (w >= 2000) begin
                checks++;
                failures++;
                $display("FAIL s_data_timeout actual=beat%0d required=accepted", i);
                s_data_if.valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            drv_seq++;
        end
        s_data_if.valid = 1'b0;
        s_data_if.last  = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_cmd_q.size() != 0 || exp_beat_q.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(name, 512'(exp_cmd_q.size() + exp_beat_q.size()), 512'd0);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        s_cmd_if.valid    = 1'b0;
        s_cmd_if.address  = '0;
        s_cmd_if.length   = '0;
        s_data_if.valid   = 1'b0;
        s_data_if.data    = '0;
        s_data_if.keep    = '0;
        s_data_if.last    = 1'b0;
        m_cmd_if.ready    = 1'b1;
        m_data_if.ready   = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst s_cmd.ready",  512'(s_cmd_if.ready), 512'd0);
        chk("rst m_cmd.valid",  512'(m_cmd_if.valid), 512'd0);
        chk("rst m_data.valid", 512'(m_data_if.valid), 512'd0);
        chk("rst m_cmd.address", 512'(m_cmd_if.address), 512'd0);
        chk("rst chunk_count",  512'(chunk_count), 512'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("post-rst s_cmd.ready", 512'(s_cmd_if.ready), 512'd1);

        // Control entry: one chunk, one beat
        push_chunk(64'h8000_0040, 32'h40, 1'b1);
        fork
            begin
                send_cmd(64'h8000_0040, 32'h40);
                chk("calc m_cmd.valid", 512'(m_cmd_if.valid), 512'd0);
            end
            send_data(1, 1);
        join
        chk("ctrl s_cmd.ready", 512'(s_cmd_if.ready), 512'd1);
        @(posedge clk);
        #1;
        chk("ctrl s_cmd.ready+1", 512'(s_cmd_if.ready), 512'd1);
        chk("ctrl m_cmd.valid", 512'(m_cmd_if.valid), 512'd0);
        wait_drain("ctrl drain");
        chk("ctrl chunk_count", 512'(chunk_count), 512'd1);

        // Unaligned start crossing a 4 KiB boundary
        push_chunk(64'h0FC0, 32'h40, 1'b0);
        push_chunk(64'h1000, 32'hC0, 1'b1);
        fork
            send_cmd(64'h0FC0, 32'h100);
            send_data(4, 4);
        join
        wait_drain("unaligned drain");
        chk("unaligned chunk_count", 512'(chunk_count), 512'd3);
        chk("unaligned mismatch", 512'(last_mismatch_count), 512'd0);

        // Zero length: discarded, no downstream command
        send_cmd(64'h5000, 32'h0);
        chk("zero zero_len_count", 512'(zero_len_count), 512'd1);
        chk("zero s_cmd.ready", 512'(s_cmd_if.ready), 512'd1);
        repeat (4) begin
            @(negedge clk);
            chk("zero m_cmd.valid", 512'(m_cmd_if.valid), 512'd0);
        end

        // Upstream last on beat 1 of a 2-beat command: two disagreements
        push_chunk(64'h2000, 32'h80, 1'b1);
        fork
            send_cmd(64'h2000, 32'h80);
            send_data(2, 1);
        join
        wait_drain("mismatch drain");
        chk("mismatch count", 512'(last_mismatch_count), 512'd2);
        chk("mismatch chunk_count", 512'(chunk_count), 512'd4);

        // Command backpressure then toggling data backpressure
        m_cmd_if.ready = 1'b0;
        data_done = 1'b0;
        push_chunk(64'h3000, 32'h1000, 1'b1);
        fork
            begin
                send_data(64, 64);
                data_done = 1'b1;
            end
            begin
                send_cmd(64'h3000, 32'h1000);
                n = 0;
                @(negedge clk);
                while (!m_cmd_if.valid && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                for (int i = 0; i < 10; i++) begin
                    chk("bp m_cmd.valid",   512'(m_cmd_if.valid), 512'd1);
                    chk("bp m_cmd.address", 512'(m_cmd_if.address), 512'h3000);
                    chk("bp m_cmd.length",  512'(m_cmd_if.length), 512'h1000);
                    chk("bp s_data.ready",  512'(s_data_if.ready), 512'd0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                m_cmd_if.ready = 1'b1;
                while (!data_done) begin
                    @(posedge clk);
                    #1;
                    m_data_if.ready = ~m_data_if.ready;
                end
                m_data_if.ready = 1'b1;
            end
        join
        wait_drain("bp drain");
        chk("bp chunk_count", 512'(chunk_count), 512'd5);

        // Full 2 MiB page above the 4 GiB line
        for (int k = 0; k < 512; k++) begin
            push_chunk(64'h1_0000_0000 + 64'(k) * 64'h1000, 32'h1000, k == 511);
        end
        fork
            send_cmd(64'h1_0000_0000, 32'h20_0000);
            send_data(32768, 32768);
        join
        wait_drain("page drain");
        chk("page chunk_count", 512'(chunk_count), 512'd517);
        chk("page mismatch", 512'(last_mismatch_count), 512'd2);

        // Asynchronous reset while beat 10 of a chunk is presented
        begin
            cmd_t  c;
            beat_t b;
            c.addr = 64'h6000;
            c.len  = 32'h1000;
            exp_cmd_q.push_back(c);
            for (int i = 0; i < 9; i++) begin
                b.data = word_of(exp_seq);
                b.keep = keep_of(exp_seq);
                b.last = 1'b0;
                exp_beat_q.push_back(b);
                exp_seq++;
            end
        end
        fork
            send_cmd(64'h6000, 32'h1000);
            send_data(9, 0);
        join
        s_data_if.valid = 1'b1;
        s_data_if.data  = word_of(drv_seq);
        s_data_if.keep  = keep_of(drv_seq);
        chk("pre-rst m_data.valid", 512'(m_data_if.valid), 512'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("async m_data.valid", 512'(m_data_if.valid), 512'd0);
        chk("async m_cmd.valid",  512'(m_cmd_if.valid), 512'd0);
        chk("async s_data.ready", 512'(s_data_if.ready), 512'd0);
        chk("async s_cmd.ready",  512'(s_cmd_if.ready), 512'd0);
        chk("async chunk_count",  512'(chunk_count), 512'd0);
        chk("async zero_len_count", 512'(zero_len_count), 512'd0);
        chk("async mismatch",     512'(last_mismatch_count), 512'd0);
        chk("async sb empty", 512'(exp_cmd_q.size() + exp_beat_q.size()), 512'd0);
        s_data_if.valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("rerst s_cmd.ready", 512'(s_cmd_if.ready), 512'd1);

        // Normal operation after reset
        push_chunk(64'h7000, 32'h40, 1'b1);
        fork
            send_cmd(64'h7000, 32'h40);
            send_data(1, 1);
        join
        wait_drain("after-rst drain");
        chk("after-rst chunk_count", 512'(chunk_count), 512'd1);
        chk("after-rst mismatch", 512'(last_mismatch_count), 512'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
